// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : multi_edge_detector
//  Description : Multi-channel edge-event unit. Each channel synchronises an
//                asynchronous input, rejects glitches shorter than DEBOUNCE
//                cycles, and reports qualified rising/falling edges as a
//                one-cycle pulse, a sticky pending flag and a saturating
//                event counter with a shared registered readout port.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8,
    localparam int c_SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   sig_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    input  logic [c_SEL_W-1:0]    cnt_sel,
    input  logic                  cnt_clr,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  any_pending,
    output logic [CNT_W-1:0]      cnt_out
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] w_cnt_arr [CHANNELS];
    logic [CNT_W-1:0] w_cnt_out_d;
    logic [CNT_W-1:0] r_cnt_out_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync_q;
        logic [SYNC_STAGES-1:0] w_sync_d;
        logic                   w_s;
        logic                   r_filt_q;
        logic                   w_filt_d;
        logic [c_DB_W-1:0]      r_db_q;
        logic [c_DB_W-1:0]      w_db_d;
        logic                   r_prev_q;
        logic                   w_prev_d;
        logic                   w_rise;
        logic                   w_fall;
        logic                   w_event;
        logic                   w_cnt_hit;
        logic                   r_pulse_q;
        logic                   w_pulse_d;
        logic                   r_pend_q;
        logic                   w_pend_d;
        logic [CNT_W-1:0]       r_cnt_q;
        logic [CNT_W-1:0]       w_cnt_d;

        assign w_s = r_sync_q[SYNC_STAGES-1];

        // Synchroniser shift, debounce filter and edge qualification.
        always_comb begin
            w_sync_d = {r_sync_q[SYNC_STAGES-2:0], sig_in[gi]};

            // Any sample matching the filtered level restarts the window.
            w_filt_d = r_filt_q;
            w_db_d   = '0;
            if (w_s != r_filt_q) begin
                if (r_db_q == c_DB_LAST) begin
                    w_filt_d = w_s;
                end else begin
                    w_db_d = r_db_q + c_DB_ONE;
                end
            end

            w_prev_d  = r_filt_q;
            w_rise    = r_filt_q & ~r_prev_q;
            w_fall    = ~r_filt_q & r_prev_q;
            w_event   = (w_rise & mode[2*gi]) | (w_fall & mode[2*gi+1]);
            w_pulse_d = w_event;
            // A new event wins over a coincident clear so nothing is lost.
            w_pend_d  = w_event | (r_pend_q & ~clr[gi]);

            // Clear and a coincident event leave a count of one.
            w_cnt_hit = cnt_clr && (cnt_sel == c_SEL_W'(gi));
            w_cnt_d   = r_cnt_q;
            if (w_cnt_hit) begin
                w_cnt_d = w_event ? c_CNT_ONE : '0;
            end else if (w_event && (r_cnt_q != c_CNT_MAX)) begin
                w_cnt_d = r_cnt_q + c_CNT_ONE;
            end
        end

        // Per-channel state registers; reset aborts any in-flight event.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync_q  <= '0;
                r_filt_q  <= 1'b0;
                r_db_q    <= '0;
                r_prev_q  <= 1'b0;
                r_pulse_q <= 1'b0;
                r_pend_q  <= 1'b0;
                r_cnt_q   <= '0;
            end else begin
                r_sync_q  <= w_sync_d;
                r_filt_q  <= w_filt_d;
                r_db_q    <= w_db_d;
                r_prev_q  <= w_prev_d;
                r_pulse_q <= w_pulse_d;
                r_pend_q  <= w_pend_d;
                r_cnt_q   <= w_cnt_d;
            end
        end

        assign pulse[gi]     = r_pulse_q;
        assign pending[gi]   = r_pend_q;
        assign w_cnt_arr[gi] = r_cnt_q;
    end

    // Counter readout mux; an out-of-range index reads as zero.
    always_comb begin
        w_cnt_out_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cnt_sel == c_SEL_W'(k)) begin
                w_cnt_out_d = w_cnt_arr[k];
            end
        end
    end

    // Readout register, sampling the count before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_out_q <= '0;
        end else begin
            r_cnt_out_q <= w_cnt_out_d;
        end
    end

    assign cnt_out     = r_cnt_out_q;
    assign any_pending = |pending;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_edge_detector
//  Description : Self-checking bench for multi_edge_detector (5 channels,
//                2 sync stages, debounce 4, 2-bit counters). Table-driven
//                cycle vectors plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sig_in;
    logic [9:0] mode;
    logic [4:0] clr;
    logic [2:0] cnt_sel;
    logic       cnt_clr;
    logic [4:0] pulse;
    logic [4:0] pending;
    logic       any_pending;
    logic [1:0] cnt_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .CHANNELS    (5),
        .SYNC_STAGES (2),
        .DEBOUNCE    (4),
        .CNT_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .mode        (mode),
        .clr         (clr),
        .cnt_sel     (cnt_sel),
        .cnt_clr     (cnt_clr),
        .pulse       (pulse),
        .pending     (pending),
        .any_pending (any_pending),
        .cnt_out     (cnt_out)
    );

    typedef struct {
        logic [4:0] sig;
        logic [9:0] md;
        logic [4:0] cl;
        logic [2:0] sel;
        logic [4:0] e_pulse;
        logic [4:0] e_pend;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n, input int ch, output int np);
        np = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (pulse[ch]) np++;
        end
    endtask

    task automatic add_row(input logic [4:0] s, input logic [9:0] m, input logic [4:0] c,
                           input logic [2:0] sl, input logic [4:0] ep, input logic [4:0] epd,
                           input logic [1:0] ec);
        vec_t v;
        v.sig = s; v.md = m; v.cl = c; v.sel = sl;
        v.e_pulse = ep; v.e_pend = epd; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int np;
        int sat_exp [5];
        sat_exp = '{1, 2, 3, 3, 3};

        rst = 1'b1; sig_in = '0; mode = '0; clr = '0; cnt_sel = '0; cnt_clr = 1'b0;
        repeat (3) tick();
        check("reset_pulse", 32'(pulse), 32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_any", 32'(any_pending), 32'h0);
        check("reset_cnt_out", 32'(cnt_out), 32'h0);

        rst = 1'b0; mode = 10'h001;
        repeat (3) tick();

        // Rise on ch0 (mode rise only): pulse on edge 7, fall ignored, then clear.
        for (int r = 1; r <= 6; r++) add_row(5'h01, 10'h001, 5'h00, 3'd0, 5'h00, 5'h00, 2'd0);
        add_row(5'h01, 10'h001, 5'h00, 3'd0, 5'h01, 5'h01, 2'd0);
        add_row(5'h01, 10'h001, 5'h00, 3'd0, 5'h00, 5'h01, 2'd1);
        for (int r = 9; r <= 15; r++) add_row(5'h00, 10'h001, 5'h00, 3'd0, 5'h00, 5'h01, 2'd1);
        add_row(5'h00, 10'h001, 5'h01, 3'd0, 5'h00, 5'h00, 2'd1);
        add_row(5'h00, 10'h001, 5'h00, 3'd0, 5'h00, 5'h00, 2'd1);
        // Rise on ch3 with clr coincident with the event, then clr one cycle later.
        for (int r = 1; r <= 6; r++) add_row(5'h08, 10'h040, 5'h00, 3'd3, 5'h00, 5'h00, 2'd0);
        add_row(5'h08, 10'h040, 5'h08, 3'd3, 5'h08, 5'h08, 2'd0);
        add_row(5'h08, 10'h040, 5'h08, 3'd3, 5'h00, 5'h00, 2'd1);
        add_row(5'h08, 10'h040, 5'h00, 3'd3, 5'h00, 5'h00, 2'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            sig_in = tbl[i].sig; mode = tbl[i].md; clr = tbl[i].cl;
            cnt_sel = tbl[i].sel; cnt_clr = 1'b0;
            tick();
            check($sformatf("row%0d_pulse", i), 32'(pulse), 32'(tbl[i].e_pulse));
            check($sformatf("row%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
            check($sformatf("row%0d_any", i), 32'(any_pending), 32'(|tbl[i].e_pend));
            check($sformatf("row%0d_cnt_out", i), 32'(cnt_out), 32'(tbl[i].e_cnt));
        end
        clr = '0;

        // ch1 both edges: 3-cycle glitch rejected, held level gives rise and fall.
        mode = 10'h00C; cnt_sel = 3'd1;
        sig_in = 5'h0A;
        run(3, 1, np);
        begin
            int np2;
            sig_in = 5'h08;
            run(12, 1, np2);
            check("glitch_pulses", 32'(np + np2), 32'd0);
        end
        check("glitch_pending", 32'(pending[1]), 32'd0);
        sig_in = 5'h0A;
        run(10, 1, np);
        check("both_rise_pulses", 32'(np), 32'd1);
        check("both_rise_pending", 32'(pending[1]), 32'd1);
        sig_in = 5'h08;
        run(10, 1, np);
        check("both_fall_pulses", 32'(np), 32'd1);
        check("both_cnt", 32'(cnt_out), 32'd2);

        // ch2 counter saturation at 3, then clear coincident with an event.
        mode = 10'h010; cnt_sel = 3'd2;
        for (int r = 0; r < 5; r++) begin
            sig_in[2] = 1'b1;
            run(10, 2, np);
            check($sformatf("sat%0d_rise", r), 32'(np), 32'd1);
            check($sformatf("sat%0d_cnt", r), 32'(cnt_out), 32'(sat_exp[r]));
            sig_in[2] = 1'b0;
            run(10, 2, np);
            check($sformatf("sat%0d_fall", r), 32'(np), 32'd0);
        end
        sig_in[2] = 1'b1;
        run(6, 2, np);
        check("clrhit_early", 32'(np), 32'd0);
        cnt_clr = 1'b1;
        tick();
        check("clrhit_pulse", 32'(pulse[2]), 32'd1);
        cnt_clr = 1'b0;
        tick();
        check("clrhit_cnt", 32'(cnt_out), 32'd1);

        // Out-of-range select reads zero and its clear does nothing.
        cnt_sel = 3'd5; cnt_clr = 1'b1;
        tick();
        check("oor_cnt_out", 32'(cnt_out), 32'd0);
        cnt_clr = 1'b0; cnt_sel = 3'd2;
        tick();
        check("oor_no_clear", 32'(cnt_out), 32'd1);
        sig_in[2] = 1'b0;
        run(10, 2, np);

        // ch0 mode off while toggling, then rise-only enabled.
        mode = 10'h000; cnt_sel = 3'd0;
        begin
            int tot;
            tot = 0;
            for (int r = 0; r < 4; r++) begin
                sig_in[0] = (r % 2 == 0);
                run(10, 0, np);
                tot += np;
            end
            check("off_pulses", 32'(tot), 32'd0);
        end
        check("off_pending", 32'(pending[0]), 32'd0);
        check("off_cnt", 32'(cnt_out), 32'd1);
        mode = 10'h001;
        sig_in[0] = 1'b1;
        run(10, 0, np);
        check("on_rise_pulses", 32'(np), 32'd1);
        sig_in[0] = 1'b0;
        run(10, 0, np);
        check("on_fall_pulses", 32'(np), 32'd0);
        check("on_pending", 32'(pending[0]), 32'd1);
        check("on_cnt", 32'(cnt_out), 32'd2);

        // Reset two cycles into a ch1 debounce window; input stays high.
        mode = 10'h004; cnt_sel = 3'd1;
        sig_in[1] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            check($sformatf("rst%0d_pulse", r), 32'(pulse), 32'h0);
            check($sformatf("rst%0d_pending", r), 32'(pending), 32'h0);
            check($sformatf("rst%0d_any", r), 32'(any_pending), 32'h0);
            check($sformatf("rst%0d_cnt", r), 32'(cnt_out), 32'h0);
        end
        rst = 1'b0;
        run(6, 1, np);
        check("post_rst_early", 32'(np), 32'd0);
        tick();
        check("post_rst_pulse", 32'(pulse), 32'h02);
        tick();
        check("post_rst_pulse_end", 32'(pulse), 32'h00);
        check("post_rst_pending", 32'(pending), 32'h02);
        check("post_rst_cnt", 32'(cnt_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
